// File: rtl/bcd_score_accum.sv
// bcd_score_accum: registered BCD score accumulator with game-state tracking.
// Define SCORE_HISCORE_EN to compile in the hiscore register and new_record flag.
module bcd_score_accum #(
    parameter int DIGITS   = 4,
    parameter bit SAT_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [3:0]            step,
    input  logic [1:0]            gamestate,
    output logic [4*DIGITS-1:0]   score,
    output logic [4*DIGITS-1:0]   hiscore,
    output logic                  new_record,
    output logic                  overflow
);
    localparam logic [1:0] IDLE = 2'b00, RUNNING = 2'b01, OVER = 2'b10;
    localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};

    logic [1:0]          prev_state;
    logic                start_ev, add_ev;
    logic [3:0]          addend;
    logic [DIGITS:0]     carry;
    logic [4*DIGITS-1:0] sum, next_score;

    assign start_ev = gamestate == RUNNING && (prev_state == IDLE || prev_state == OVER);
    assign add_ev   = tick && gamestate == RUNNING && !start_ev;
    assign addend   = step > 4'd9 ? 4'd9 : step;
    assign carry[0] = 1'b0;

    // Decimal ripple: each digit wraps past 9 and carries into the next.
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        logic [4:0] raw;
        assign raw = {1'b0, score[4*d+:4]} + {1'b0, (d == 0 ? addend : 4'd0)} + {4'd0, carry[d]};
        assign carry[d+1] = raw > 5'd9;
        assign sum[4*d+:4] = carry[d+1] ? raw[3:0] - 4'd10 : raw[3:0];
    end

    assign next_score = carry[DIGITS] && SAT_MODE ? NINES : sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= IDLE;
            score      <= '0;
            overflow   <= 1'b0;
        end else begin
            prev_state <= gamestate;
            if (start_ev) begin
                score    <= '0;
                overflow <= 1'b0;
            end else if (add_ev) begin
                score    <= next_score;
                overflow <= overflow | carry[DIGITS];
            end
        end
    end

`ifdef SCORE_HISCORE_EN
    logic end_ev;
    assign end_ev = gamestate == OVER && prev_state == RUNNING;
    // Packed BCD orders the same as binary, so a plain compare suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hiscore    <= '0;
            new_record <= 1'b0;
        end else if (start_ev) begin
            new_record <= 1'b0;
        end else if (end_ev && score > hiscore) begin
            hiscore    <= score;
            new_record <= 1'b1;
        end
    end
`else
    assign hiscore    = '0;
    assign new_record = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_score_accum.sv
// tb_bcd_score_accum: random and directed checks of bcd_score_accum (saturating and wrapping builds)
// against a decimal-integer reference model.
module tb_bcd_score_accum;
`ifdef SCORE_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic [3:0]  step = '0;
    logic [1:0]  gamestate = '0;
    logic [15:0] score_s, hiscore_s, score_w, hiscore_w;
    logic        nr_s, ov_s, nr_w, ov_w;
    int          n_chk = 0, n_err = 0;
    int          sc[2], hi[2], nr[2], ov[2], m_prev;

    bcd_score_accum #(.DIGITS(4), .SAT_MODE(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .step(step), .gamestate(gamestate),
        .score(score_s), .hiscore(hiscore_s), .new_record(nr_s), .overflow(ov_s));
    bcd_score_accum #(.DIGITS(4), .SAT_MODE(0)) dut_w (
        .clk(clk), .rst(rst), .tick(tick), .step(step), .gamestate(gamestate),
        .score(score_w), .hiscore(hiscore_w), .new_record(nr_w), .overflow(ov_w));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            sc[m] = 0; hi[m] = 0; nr[m] = 0; ov[m] = 0;
        end
        m_prev = 0;
    endtask

    task automatic model_edge();
        int st, s;
        bit start, endv;
        st    = step > 9 ? 9 : int'(step);
        start = gamestate == 1 && (m_prev == 0 || m_prev == 2);
        endv  = gamestate == 2 && m_prev == 1;
        for (int m = 0; m < 2; m++) begin
            if (start) begin
                sc[m] = 0; nr[m] = 0; ov[m] = 0;
            end else if (tick && gamestate == 1) begin
                s = sc[m] + st;
                if (s > 9999) begin
                    ov[m] = 1;
                    sc[m] = m == 0 ? 9999 : s - 10000;
                end else sc[m] = s;
            end
            if (HI_EN && endv && sc[m] > hi[m]) begin
                hi[m] = sc[m]; nr[m] = 1;
            end
        end
        m_prev = int'(gamestate);
    endtask

    task automatic check_all();
        chk("score_sat", score_s, to_bcd(sc[0]));
        chk("score_wrap", score_w, to_bcd(sc[1]));
        chk("ovf_sat", ov_s, ov[0]);
        chk("ovf_wrap", ov_w, ov[1]);
        chk("hiscore_sat", hiscore_s, to_bcd(hi[0]));
        chk("hiscore_wrap", hiscore_w, to_bcd(hi[1]));
        chk("newrec_sat", nr_s, nr[0]);
        chk("newrec_wrap", nr_w, nr[1]);
    endtask

    task automatic cyc(input logic t, input logic [3:0] s, input logic [1:0] g);
        tick = t; step = s; gamestate = g;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int n, input logic [3:0] s);
        for (int i = 0; i < n; i++) cyc(1'b1, s, 2'b01);
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 2'b00);
        cyc(0, 0, 2'b01);
        ticks(12, 4'd1);
        chk("twelve_ones", score_s, 16'h0012);
        ticks(9, 4'd9);
        ticks(1, 4'd2);
        chk("at_95", score_s, 16'h0095);
        ticks(1, 4'd7);
        chk("double_carry", score_s, 16'h0102);
        ticks(1, 4'd0);
        chk("step_zero", score_s, 16'h0102);
        ticks(1, 4'd15);
        chk("step_clamp", score_s, 16'h0111);
        cyc(1, 5, 2'b00);
        chk("tick_idle", score_s, 16'h0111);
        cyc(0, 0, 2'b01);
        cyc(0, 0, 2'b10);
        cyc(0, 0, 2'b01);
        ticks(4, 4'd9);
        ticks(1, 4'd6);
        chk("at_42", score_s, 16'h0042);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_score", score_s, 16'h0000);
        chk("async_rst_hi", hiscore_s, 16'h0000);
        check_all();
        rst = 1'b0;
        cyc(0, 0, 2'b01);
        ticks(27, 4'd9);
        ticks(1, 4'd7);
        chk("game1_250", score_s, 16'h0250);
        cyc(0, 0, 2'b10);
        chk("game1_hi", hiscore_s, HI_EN ? 32'h0250 : 32'h0);
        chk("game1_nr", nr_s, HI_EN ? 32'h1 : 32'h0);
        cyc(0, 0, 2'b01);
        chk("game2_clear", score_s, 16'h0000);
        chk("game2_nr", nr_s, 32'h0);
        ticks(27, 4'd9);
        ticks(1, 4'd7);
        cyc(0, 0, 2'b10);
        chk("game2_hi_eq", hiscore_s, HI_EN ? 32'h0250 : 32'h0);
        chk("game2_nr_eq", nr_s, 32'h0);
        cyc(1, 6, 2'b01);
        chk("start_drops_tick", score_s, 16'h0000);
        ticks(1, 4'd3);
        cyc(1, 4, 2'b11);
        chk("pause_hold", score_s, 16'h0003);
        cyc(0, 0, 2'b11);
        cyc(0, 0, 2'b01);
        chk("resume_keep", score_s, 16'h0003);
        ticks(1, 4'd2);
        chk("resume_add", score_s, 16'h0005);
        cyc(0, 0, 2'b10);
        cyc(0, 0, 2'b01);
        ticks(1110, 4'd9);
        ticks(1, 4'd8);
        chk("at_9998", score_s, 16'h9998);
        ticks(1, 4'd5);
        chk("sat_9999", score_s, 16'h9999);
        chk("sat_ovf", ov_s, 32'h1);
        chk("wrap_0003", score_w, 16'h0003);
        chk("wrap_ovf", ov_w, 32'h1);
        ticks(1, 4'd5);
        chk("sat_hold", score_s, 16'h9999);
        chk("wrap_0008", score_w, 16'h0008);
        cyc(0, 0, 2'b10);
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] g;
            g = $urandom_range(0, 7) == 0 ? 2'($urandom_range(0, 3)) : gamestate;
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), g);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
